stim_pattern_gen: RTL and testbench

- Parametrised stimulus source for simulation benches and on-chip self-test.
- Successor to the free-running counter-plus-register data stage: adds a valid/ready handshake with backpressure, selectable pattern modes (increment, decrement, LFSR, constant), programmable start value, step and burst length, last-beat flag and a done pulse.
- Sits between bench or self-test control and any DUT input using the valid/ready data convention.

---
 rtl/stim_pkg.sv | 17 +
 rtl/stim_next_value.sv | 26 ++
 rtl/stim_pattern_gen.sv | 153 +++++++++++++++
 tb/tb_stim_pattern_gen.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus pattern generator: pattern modes and FSM states.
package stim_pkg;

   // Pattern modes as presented on the mode input
   localparam logic [1:0] MODE_INCR  = 2'd0;
   localparam logic [1:0] MODE_DECR  = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;
   localparam logic [1:0] MODE_CONST = 2'd3;

   // Burst sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/stim_next_value.sv
// Combinational successor of the current pattern word for the selected mode.
// All arithmetic wraps modulo 2^DATA_WIDTH; the LFSR is a right-shifting Galois form.
module stim_next_value
   import stim_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(8'hB8)
) (
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] cur_value,
   input  logic [DATA_WIDTH-1:0] step,
   output logic [DATA_WIDTH-1:0] next_value
);

   // Select the next word; constant mode (and any unknown code) holds the value
   always_comb begin
      next_value = cur_value;
      case (mode)
         MODE_INCR: next_value = cur_value + step;
         MODE_DECR: next_value = cur_value - step;
         MODE_LFSR: next_value = (cur_value >> 1) ^ (cur_value[0] ? LFSR_POLY : '0);
         default:   next_value = cur_value;
      endcase
   end

endmodule

// File: rtl/stim_pattern_gen.sv
// Stimulus pattern generator: on start it streams a pattern over a valid/ready
// interface, counts accepted beats, flags the final beat of a bounded burst and
// pulses done afterwards. abort ends a running burst without a done pulse.
module stim_pattern_gen
   import stim_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    CNT_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(8'hB8),
   parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(1)
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] init,
   input  logic [DATA_WIDTH-1:0] step,
   input  logic [CNT_WIDTH-1:0]  length,
   output logic                  ovalid,
   input  logic                  oready,
   output logic [DATA_WIDTH-1:0] odata,
   output logic                  olast,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  count
);

   state_t                state_q,  state_d;
   logic [1:0]            mode_q,   mode_d;
   logic [DATA_WIDTH-1:0] step_q,   step_d;
   logic [CNT_WIDTH-1:0]  length_q, length_d;
   logic [DATA_WIDTH-1:0] odata_q,  odata_d;
   logic [CNT_WIDTH-1:0]  count_q,  count_d;
   logic                  ovalid_q, ovalid_d;
   logic                  olast_q,  olast_d;
   logic                  busy_q,   busy_d;
   logic                  done_q,   done_d;

   logic                  xfer;
   logic [CNT_WIDTH-1:0]  count_inc;
   logic [DATA_WIDTH-1:0] next_value;

   assign xfer      = ovalid_q & oready;
   assign count_inc = count_q + CNT_WIDTH'(1);

   stim_next_value #(
      .DATA_WIDTH (DATA_WIDTH),
      .LFSR_POLY  (LFSR_POLY)
   ) u_next_value (
      .mode       (mode_q),
      .cur_value  (odata_q),
      .step       (step_q),
      .next_value (next_value)
   );

   // Next-state and next-output computation; every output is registered so the
   // interface never shows combinational paths from the inputs
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      step_d   = step_q;
      length_d = length_q;
      odata_d  = odata_q;
      count_d  = count_q;
      ovalid_d = ovalid_q;
      olast_d  = olast_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d   = mode;
               step_d   = step;
               length_d = length;
               odata_d  = (mode == MODE_LFSR && init == '0) ? LFSR_SEED : init;
               count_d  = '0;
               ovalid_d = 1'b1;
               olast_d  = (length == CNT_WIDTH'(1));
               busy_d   = 1'b1;
               state_d  = ST_RUN;
            end
         end

         ST_RUN: begin
            if (xfer) begin
               count_d = count_inc;
               odata_d = next_value;
               olast_d = (length_q != '0) && (count_inc == length_q - CNT_WIDTH'(1));
            end
            if (abort) begin
               ovalid_d = 1'b0;
               olast_d  = 1'b0;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end else if (xfer && olast_q) begin
               ovalid_d = 1'b0;
               olast_d  = 1'b0;
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end
         end

         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // State, configuration and output registers with asynchronous clear
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q  <= ST_IDLE;
         mode_q   <= '0;
         step_q   <= '0;
         length_q <= '0;
         odata_q  <= '0;
         count_q  <= '0;
         ovalid_q <= 1'b0;
         olast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         step_q   <= step_d;
         length_q <= length_d;
         odata_q  <= odata_d;
         count_q  <= count_d;
         ovalid_q <= ovalid_d;
         olast_q  <= olast_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign ovalid = ovalid_q;
   assign odata  = odata_q;
   assign olast  = olast_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign count  = count_q;

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Testbench for stim_pattern_gen: directed bursts plus randomized bursts with
// random backpressure and aborts, checked against a closed-form pattern model.
module tb_stim_pattern_gen;
   import stim_pkg::*;

   localparam logic [7:0] POLY = 8'hB8;
   localparam logic [7:0] SEED = 8'h01;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        start   = 1'b0;
   logic        abort   = 1'b0;
   logic        oready  = 1'b0;
   logic [1:0]  mode    = 2'd0;
   logic [7:0]  init    = 8'd0;
   logic [7:0]  step    = 8'd0;
   logic [15:0] length  = 16'd0;
   logic        ovalid, olast, busy, done;
   logic [7:0]  odata;
   logic [15:0] count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Per-cycle samples of one burst
   logic        s_valid[$], s_ready[$], s_last[$], s_done[$], s_busy[$], s_abort[$];
   logic [7:0]  s_data[$];
   logic [15:0] s_count[$];
   bit          rec_timeout;

   // Accepted beats extracted from the samples
   logic [7:0]  b_data[$];
   logic        b_last[$];
   int          last_idx, done_idx, done_cnt;

   always #5 sys_clk = ~sys_clk;

   stim_pattern_gen dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .start   (start),
      .abort   (abort),
      .mode    (mode),
      .init    (init),
      .step    (step),
      .length  (length),
      .ovalid  (ovalid),
      .oready  (oready),
      .odata   (odata),
      .olast   (olast),
      .busy    (busy),
      .done    (done),
      .count   (count)
   );

   // Reference: the k-th beat of a burst, straight from the pattern definitions
   function automatic logic [7:0] exp_beat(input logic [1:0] m, input logic [7:0] i,
                                           input logic [7:0] s, input int k);
      int         v;
      logic [7:0] r;
      case (m)
         MODE_INCR: begin v = int'(i) + k * int'(s); r = v[7:0]; end
         MODE_DECR: begin v = int'(i) - k * int'(s); r = v[7:0]; end
         MODE_LFSR: begin
            r = (i == 8'd0) ? SEED : i;
            repeat (k) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
         end
         default:   r = i;
      endcase
      return r;
   endfunction

   task automatic do_start(input logic [1:0] m, input logic [7:0] i, input logic [7:0] s,
                           input logic [15:0] l);
      @(negedge sys_clk);
      mode = m; init = i; step = s; length = l; start = 1'b1; oready = 1'b0;
      @(negedge sys_clk);
      start = 1'b0;
      mode = 2'($urandom); init = 8'($urandom); step = 8'($urandom); length = 16'($urandom);
   endtask

   // Drives oready/abort/start cycle by cycle and records what the DUT shows
   task automatic record_burst(input int max_cycles, input int stall_beat, input int stall_len,
                               input bit rand_ready, input int abort_xfer,
                               input bit abort_with_xfer, input int start_at);
      int nx;
      int stalled;
      bit rdy, ab, aborted;
      nx = 0; stalled = 0; aborted = 0;
      s_valid.delete(); s_ready.delete(); s_last.delete(); s_done.delete();
      s_busy.delete(); s_abort.delete(); s_data.delete(); s_count.delete();
      rec_timeout = 1'b1;
      for (int c = 0; c < max_cycles; c++) begin
         s_valid.push_back(ovalid); s_last.push_back(olast); s_done.push_back(done);
         s_busy.push_back(busy); s_data.push_back(odata); s_count.push_back(count);
         if (!busy) begin
            s_ready.push_back(1'b0); s_abort.push_back(1'b0);
            rec_timeout = 1'b0;
            break;
         end
         rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (ovalid && nx == stall_beat && stalled < stall_len) begin
            rdy = 1'b0;
            stalled++;
         end
         ab = 1'b0;
         if (abort_xfer > 0 && !aborted) begin
            if (abort_with_xfer) begin
               if (ovalid && rdy && nx == abort_xfer - 1) begin ab = 1'b1; aborted = 1'b1; end
            end else if (nx == abort_xfer) begin
               ab = 1'b1; rdy = 1'b0; aborted = 1'b1;
            end
         end
         if (ovalid && rdy) nx++;
         start  = (c == start_at);
         oready = rdy;
         abort  = ab;
         s_ready.push_back(rdy); s_abort.push_back(ab);
         @(negedge sys_clk);
      end
      start = 1'b0; abort = 1'b0; oready = 1'b0;
   endtask

   task automatic extract_beats();
      b_data.delete(); b_last.delete();
      last_idx = -1; done_idx = -1; done_cnt = 0;
      foreach (s_valid[i]) begin
         if (s_valid[i] && s_ready[i]) begin
            b_data.push_back(s_data[i]); b_last.push_back(s_last[i]); last_idx = i;
         end
         if (s_done[i]) begin
            done_cnt++;
            if (done_idx < 0) done_idx = i;
         end
      end
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      #12;
      total_cnt++;
      if ({ovalid, olast, busy, done} !== 4'b0000)
         $display("[TB] FAIL reset flags: got %b expected 0000", {ovalid, olast, busy, done});
      else pass_cnt++;
      total_cnt++;
      if (odata !== 8'd0) $display("[TB] FAIL reset odata: got %0h expected 0", odata);
      else pass_cnt++;
      total_cnt++;
      if (count !== 16'd0) $display("[TB] FAIL reset count: got %0d expected 0", count);
      else pass_cnt++;
      @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic test_incr();
      logic [7:0] exp;
      do_start(MODE_INCR, 8'd250, 8'd3, 16'd4);
      record_burst(100, -1, 0, 1'b0, 0, 1'b0, -1);
      extract_beats();
      total_cnt++;
      if (rec_timeout !== 1'b0 || s_valid[0] !== 1'b1)
         $display("[TB] FAIL incr latency/timeout: got valid0=%b timeout=%b expected 1/0", s_valid[0], rec_timeout);
      else pass_cnt++;
      total_cnt++;
      if (b_data.size() != 4) $display("[TB] FAIL incr beats: got %0d expected 4", b_data.size());
      else pass_cnt++;
      for (int k = 0; k < 4 && k < b_data.size(); k++) begin
         exp = exp_beat(MODE_INCR, 8'd250, 8'd3, k);
         total_cnt++;
         if (b_data[k] !== exp || b_last[k] !== (k == 3))
            $display("[TB] FAIL incr beat%0d: got %0d/last %b expected %0d/last %b", k, b_data[k], b_last[k], exp, k == 3);
         else pass_cnt++;
      end
      total_cnt++;
      if (done_cnt != 1 || done_idx != last_idx + 1)
         $display("[TB] FAIL incr done: got cnt %0d at %0d expected 1 at %0d", done_cnt, done_idx, last_idx + 1);
      else pass_cnt++;
      total_cnt++;
      if (s_count[s_count.size()-1] !== 16'd4)
         $display("[TB] FAIL incr count: got %0d expected 4", s_count[s_count.size()-1]);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int stalls;
      do_start(MODE_INCR, 8'd250, 8'd3, 16'd4);
      record_burst(100, 1, 3, 1'b0, 0, 1'b0, -1);
      extract_beats();
      stalls = 0;
      foreach (s_valid[i]) begin
         if (s_busy[i] && !s_ready[i]) begin
            stalls++;
            total_cnt++;
            if (s_valid[i] !== 1'b1 || s_data[i] !== 8'd253 || s_count[i] !== 16'd1 || s_last[i] !== 1'b0)
               $display("[TB] FAIL stall hold: got v%b d%0d c%0d l%b expected v1 d253 c1 l0", s_valid[i], s_data[i], s_count[i], s_last[i]);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (stalls != 3) $display("[TB] FAIL stall cycles: got %0d expected 3", stalls);
      else pass_cnt++;
      total_cnt++;
      if (b_data.size() != 4 || b_data[0] !== 8'd250 || b_data[1] !== 8'd253 ||
          b_data[2] !== 8'd0 || b_data[3] !== 8'd3 || b_last[3] !== 1'b1)
         $display("[TB] FAIL stall sequence: got %0d beats, last beat %0d expected 4 beats ending 3", b_data.size(), b_data[b_data.size()-1]);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt != 1 || s_count[s_count.size()-1] !== 16'd4)
         $display("[TB] FAIL stall done/count: got %0d/%0d expected 1/4", done_cnt, s_count[s_count.size()-1]);
      else pass_cnt++;
   endtask

   task automatic test_lfsr();
      logic [7:0] exp_seq[4];
      exp_seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
      do_start(MODE_LFSR, 8'h00, 8'h00, 16'd4);
      record_burst(100, -1, 0, 1'b0, 0, 1'b0, -1);
      extract_beats();
      total_cnt++;
      if (b_data.size() != 4) $display("[TB] FAIL lfsr beats: got %0d expected 4", b_data.size());
      else pass_cnt++;
      for (int k = 0; k < 4 && k < b_data.size(); k++) begin
         total_cnt++;
         if (b_data[k] !== exp_seq[k])
            $display("[TB] FAIL lfsr beat%0d: got %0h expected %0h", k, b_data[k], exp_seq[k]);
         else pass_cnt++;
      end
      total_cnt++;
      if (done_cnt != 1 || done_idx != last_idx + 1)
         $display("[TB] FAIL lfsr done: got cnt %0d at %0d expected 1 at %0d", done_cnt, done_idx, last_idx + 1);
      else pass_cnt++;
   endtask

   task automatic test_decr_start_ignored();
      do_start(MODE_DECR, 8'd1, 8'd2, 16'd3);
      record_burst(100, -1, 0, 1'b0, 0, 1'b0, 1);
      extract_beats();
      total_cnt++;
      if (b_data.size() != 3 || b_data[0] !== 8'd1 || b_data[1] !== 8'd255 || b_data[2] !== 8'd253)
         $display("[TB] FAIL decr sequence: got %0d beats first %0d expected 1,255,253", b_data.size(), b_data[0]);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt != 1 || s_count[s_count.size()-1] !== 16'd3)
         $display("[TB] FAIL decr done/count: got %0d/%0d expected 1/3", done_cnt, s_count[s_count.size()-1]);
      else pass_cnt++;
      repeat (2) @(negedge sys_clk);
      total_cnt++;
      if (ovalid !== 1'b0 || busy !== 1'b0 || count !== 16'd3)
         $display("[TB] FAIL decr idle after: got v%b b%b c%0d expected v0 b0 c3", ovalid, busy, count);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      int a_idx;
      do_start(MODE_CONST, 8'h5A, 8'($urandom), 16'd0);
      record_burst(100, -1, 0, 1'b0, 10, 1'b0, -1);
      extract_beats();
      a_idx = -1;
      foreach (s_abort[i]) if (s_abort[i] && a_idx < 0) a_idx = i;
      total_cnt++;
      if (b_data.size() != 10) $display("[TB] FAIL abort beats: got %0d expected 10", b_data.size());
      else pass_cnt++;
      foreach (b_data[k]) begin
         total_cnt++;
         if (b_data[k] !== 8'h5A || b_last[k] !== 1'b0)
            $display("[TB] FAIL abort beat%0d: got %0h/last %b expected 5a/last 0", k, b_data[k], b_last[k]);
         else pass_cnt++;
      end
      total_cnt++;
      if (a_idx < 0 || a_idx + 1 >= s_valid.size() || s_valid[a_idx+1] !== 1'b0 || s_busy[a_idx+1] !== 1'b0 ||
          s_count[a_idx+1] !== 16'd10)
         $display("[TB] FAIL abort response: got abort idx %0d count %0d expected valid/busy low, count 10", a_idx, s_count[s_count.size()-1]);
      else pass_cnt++;
      repeat (2) @(negedge sys_clk);
      total_cnt++;
      if (done_cnt != 0 || done !== 1'b0)
         $display("[TB] FAIL abort done: got %0d pulses expected 0", done_cnt);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      bit stayed_idle;
      do_start(MODE_INCR, 8'd10, 8'd1, 16'd20);
      oready = 1'b1;
      repeat (3) @(negedge sys_clk);
      @(posedge sys_clk);
      #3;
      sys_rst = 1'b1;
      #1;
      total_cnt++;
      if ({ovalid, olast, busy, done} !== 4'b0000 || odata !== 8'd0 || count !== 16'd0)
         $display("[TB] FAIL async reset: got flags %b odata %0h count %0d expected all 0", {ovalid, olast, busy, done}, odata, count);
      else pass_cnt++;
      sys_rst = 1'b0;
      stayed_idle = 1'b1;
      repeat (5) begin
         @(negedge sys_clk);
         if (ovalid !== 1'b0 || busy !== 1'b0) stayed_idle = 1'b0;
      end
      oready = 1'b0;
      total_cnt++;
      if (stayed_idle !== 1'b1) $display("[TB] FAIL post-reset idle: got %b expected 1", stayed_idle);
      else pass_cnt++;
      do_start(MODE_INCR, 8'd7, 8'd1, 16'd2);
      record_burst(100, -1, 0, 1'b0, 0, 1'b0, -1);
      extract_beats();
      total_cnt++;
      if (b_data.size() != 2 || b_data[0] !== 8'd7 || b_data[1] !== 8'd8 || s_count[s_count.size()-1] !== 16'd2)
         $display("[TB] FAIL post-reset burst: got %0d beats count %0d expected 7,8 count 2", b_data.size(), s_count[s_count.size()-1]);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [1:0]  m;
      logic [7:0]  i, s, exp;
      logic [15:0] l;
      int          ax, exp_n;
      bit          aw, aborted;
      for (int n = 0; n < 30; n++) begin
         m = 2'($urandom); i = 8'($urandom); s = 8'($urandom);
         l = 16'($urandom_range(1, 8));
         ax = 0; aw = 1'b0;
         if ($urandom_range(0, 4) == 0) begin
            l = 16'd0; ax = $urandom_range(1, 12); aw = 1'($urandom);
         end else if ($urandom_range(0, 3) == 0) begin
            ax = $urandom_range(1, int'(l)); aw = 1'($urandom);
         end
         aborted = (ax > 0) && (aw || ax < int'(l) || l == 16'd0);
         exp_n   = aborted ? ax : int'(l);
         do_start(m, i, s, l);
         record_burst(300, -1, 0, 1'b1, ax, aw, -1);
         extract_beats();
         total_cnt++;
         if (rec_timeout !== 1'b0 || b_data.size() != exp_n)
            $display("[TB] FAIL rand%0d beats: got %0d timeout %b expected %0d", n, b_data.size(), rec_timeout, exp_n);
         else pass_cnt++;
         for (int k = 0; k < exp_n && k < b_data.size(); k++) begin
            exp = exp_beat(m, i, s, k);
            total_cnt++;
            if (b_data[k] !== exp || b_last[k] !== (l != 16'd0 && k == int'(l) - 1))
               $display("[TB] FAIL rand%0d beat%0d: got %0h/last %b expected %0h", n, k, b_data[k], b_last[k], exp);
            else pass_cnt++;
         end
         foreach (s_valid[j]) begin
            if (s_valid[j] && !s_ready[j] && !s_abort[j] && j + 1 < s_valid.size()) begin
               total_cnt++;
               if (s_valid[j+1] !== 1'b1 || s_data[j+1] !== s_data[j] || s_last[j+1] !== s_last[j])
                  $display("[TB] FAIL rand%0d hold@%0d: got %0h expected %0h", n, j, s_data[j+1], s_data[j]);
               else pass_cnt++;
            end
         end
         total_cnt++;
         if (done_cnt != (aborted ? 0 : 1) || (!aborted && done_idx != last_idx + 1))
            $display("[TB] FAIL rand%0d done: got %0d at %0d expected %0d", n, done_cnt, done_idx, aborted ? 0 : 1);
         else pass_cnt++;
         total_cnt++;
         if (s_count[s_count.size()-1] !== 16'(exp_n) || s_valid[s_valid.size()-1] !== 1'b0)
            $display("[TB] FAIL rand%0d count: got %0d expected %0d", n, s_count[s_count.size()-1], exp_n);
         else pass_cnt++;
      end
   endtask

   // Hard stop in case anything above stalls unexpectedly
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Test sequence
   initial begin
      test_reset();
      test_incr();
      test_backpressure();
      test_lfsr();
      test_decr_start_ignored();
      test_abort();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
